// File: rtl/ram_8x16_access_ctrl.sv
// Burst master for the 8x16 asynchronous single-port RAM: sequences address,
// enable, write-enable and the shared data bus from host read/write bursts.
module ram_8x16_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_en,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: cmd_* and wdata transfer on a rising edge where valid and
  // ready are both high; ready depends only on state, never on valid.

  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_FETCH  = 3'd1,
    W_SETUP  = 3'd2,
    W_STROBE = 3'd3,
    W_HOLD   = 3'd4,
    R_ADDR   = 3'd5,
    R_SAMPLE = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                done_q, done_d;
  logic                bus_drive;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          wait_d  = '0;
          state_d = cmd_write ? W_FETCH : R_ADDR;
        end
      end
      W_FETCH: begin
        if (wdata_valid) begin
          wdata_d = wdata;
          state_d = W_SETUP;
        end
      end
      W_SETUP: state_d = W_STROBE;
      W_STROBE: begin
        // done is registered, so raise it here to land in the final W_HOLD
        done_d  = (cnt_q == '0);
        state_d = W_HOLD;
      end
      W_HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = W_FETCH;
        end
      end
      R_ADDR: begin
        if (wait_q == WAIT_W'(READ_WAIT - 1)) begin
          wait_d  = '0;
          state_d = R_SAMPLE;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      R_SAMPLE: begin
        rdata_d       = ram_data;
        rdata_valid_d = 1'b1;
        done_d        = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = R_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enable is low in IDLE and W_FETCH, which always precede a write state,
  // so the RAM has released the bus before the controller drives it.
  assign bus_drive   = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);
  assign ram_data    = bus_drive ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr    = addr_q;
  assign ram_we      = (state_q == W_STROBE);
  assign ram_en      = (state_q == W_STROBE) || (state_q == R_ADDR) || (state_q == R_SAMPLE);
  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wdata_ready = (state_q == W_FETCH);
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_8x16_access_ctrl.sv
// Bench for ram_8x16_access_ctrl: asynchronous RAM model on the bus, burst driver,
// and a word-array reference memory predicting strobes, read data and timing.
module tb_ram_8x16_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_addr, cmd_len;
  logic [15:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid, busy, done;
  logic [2:0]  ram_addr;
  logic        ram_we, ram_en;
  wire  [15:0] ram_data;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [8];
  logic [15:0] ref_mem [8];
  logic [15:0] wd_arr [8];
  logic [18:0] strb_q [$];
  logic [15:0] rd_q [$];
  logic [18:0] exp_q [$];
  logic [15:0] exp_rd_q [$];
  int          done_cnt = 0;
  int          xbus_cnt = 0;

  ram_8x16_access_ctrl #(.DATA_W(16), .ADDR_W(3), .READ_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_en(ram_en), .ram_data(ram_data),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  // asynchronous RAM model plus bus monitor
  assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 16'bz;

  always @(negedge clk) begin
    if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_data;
      strb_q.push_back({ram_addr, ram_data});
    end
    if (rdata_valid) rd_q.push_back(rdata);
    if (done) done_cnt++;
    if (ram_en && $isunknown(ram_data)) xbus_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_en"},    ram_en, 0);
    chk({tag, "_we"},    ram_we, 0);
    chk({tag, "_addr"},  ram_addr, 0);
    chk({tag, "_bus"},   {16'h0, ram_data}, {16'h0, 16'hzzzz});
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rv"},    rdata_valid, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_wrdy"},  wdata_ready, 0);
    chk({tag, "_crdy"},  cmd_ready, 1);
  endtask

  // driver: one burst; inject 1 = one-cycle read command pulse while busy,
  // 2 = held read command; rst_we > 0 = reset during that write strobe
  task automatic burst(input bit wr, input logic [2:0] a, input logic [2:0] l,
                       input int stall, input int inject, input int rst_we);
    int n, idx, stall_left, nb, nwe, done_at;
    bit got, got2, rst_hit, done_rv;
    n = int'(l) + 1; idx = 0; stall_left = stall; nb = 0; nwe = 0; done_at = -1;
    got = 0; got2 = 0; rst_hit = 0; done_rv = 0;
    strb_q.delete(); rd_q.delete(); exp_q.delete(); exp_rd_q.delete(); done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      logic [2:0] ad;
      ad = 3'((int'(a) + i) % 8);
      if (wr) exp_q.push_back({ad, wd_arr[i]});
      else exp_rd_q.push_back(ref_mem[ad]);
    end
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    wdata_valid = 1'b1; wdata = wd_arr[0];
    for (int c = 0; c < 400 && !got && !rst_hit; c++) begin
      @(negedge clk);
      if (c == 0) cmd_valid = 1'b0;
      if (inject != 0 && c == 2) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2; cmd_len = 3'd0;
      end
      if (inject == 1 && c == 3) cmd_valid = 1'b0;
      if (busy) nb++;
      if (ram_we) nwe++;
      if (wr && wdata_ready) begin
        if (stall_left > 0) begin
          wdata_valid = 1'b0;
          stall_left--;
          chk("stall_en", ram_en, 0);
          chk("stall_bus", {16'h0, ram_data}, {16'h0, 16'hzzzz});
          chk("stall_we", ram_we, 0);
        end else begin
          wdata_valid = 1'b1;
          wdata = wd_arr[idx % 8];
          idx++;
        end
      end
      if (rst_we > 0 && nwe == rst_we) begin
        rst_n = 1'b0;
        rst_hit = 1'b1;
      end
      if (done) begin
        got = 1'b1; done_at = nb; done_rv = rdata_valid;
      end
    end
    if (rst_hit) begin
      @(negedge clk);
      chk_idle_reset("midrst");
      rst_n = 1'b1;
      wdata_valid = 1'b0;
      for (int i = 0; i < rst_we; i++) ref_mem[3'((int'(a) + i) % 8)] = wd_arr[i];
      repeat (4) @(negedge clk);
      chk("midrst_strobes", strb_q.size(), rst_we);
      chk("midrst_stay_idle", busy, 0);
      return;
    end
    chk("burst_timeout", got, 1);
    @(negedge clk);
    if (inject == 2) begin
      chk("held_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      chk("held_cmd_taken", busy, 1);
      cmd_valid = 1'b0;
    end
    chk("done_at", done_at, wr ? 4 * n + stall : 2 * n);
    chk("done_cnt", done_cnt, 1);
    if (wr) begin
      chk("strobe_cnt", strb_q.size(), exp_q.size());
      foreach (exp_q[i])
        chk("strobe", (i < strb_q.size()) ? strb_q[i] : 19'h7ffff, exp_q[i]);
      for (int i = 0; i < n; i++) ref_mem[3'((int'(a) + i) % 8)] = wd_arr[i];
    end else begin
      chk("done_with_rv", done_rv, 1);
      chk("rd_cnt", rd_q.size(), exp_rd_q.size());
      foreach (exp_rd_q[i])
        chk("rd_data", (i < rd_q.size()) ? {16'h0, rd_q[i]} : 32'hdead_beef, exp_rd_q[i]);
    end
    if (inject == 1) begin
      repeat (3) @(negedge clk);
      chk("pulse_ignored", busy, 0);
    end
    if (inject == 2) begin
      for (int c = 0; c < 20 && !got2; c++) begin
        @(negedge clk);
        if (done) got2 = 1'b1;
      end
      chk("held_rd_timeout", got2, 1);
      @(negedge clk);
      chk("held_rd_cnt", rd_q.size(), 1);
      chk("held_rd_data", (rd_q.size() > 0) ? {16'h0, rd_q[0]} : 32'hdead_beef, ref_mem[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; wdata_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk_idle_reset("reset");
    rst_n = 1'b1;

    // full 8-word write/read
    for (int i = 0; i < 8; i++) wd_arr[i] = 16'(i);
    burst(1'b1, 3'd0, 3'd7, 0, 0, 0);
    burst(1'b0, 3'd0, 3'd7, 0, 0, 0);

    // address wrap 6,7,0,1
    for (int i = 0; i < 4; i++) wd_arr[i] = 16'hA0A0 + 16'(i) * 16'h0101;
    burst(1'b1, 3'd6, 3'd3, 0, 0, 0);
    burst(1'b0, 3'd6, 3'd3, 0, 0, 0);

    // write data stall
    for (int i = 0; i < 8; i++) wd_arr[i] = 16'($urandom);
    burst(1'b1, 3'd2, 3'd2, 5, 0, 0);
    burst(1'b0, 3'd2, 3'd2, 0, 0, 0);

    // reset during the third write strobe of an 8-word burst
    for (int i = 0; i < 8; i++) wd_arr[i] = 16'($urandom);
    burst(1'b1, 3'd0, 3'd7, 0, 0, 3);
    burst(1'b0, 3'd0, 3'd7, 0, 0, 0);

    // command while busy: pulse ignored, held command taken after done
    for (int i = 0; i < 8; i++) wd_arr[i] = 16'($urandom);
    burst(1'b1, 3'd4, 3'd1, 0, 1, 0);
    for (int i = 0; i < 8; i++) wd_arr[i] = 16'($urandom);
    burst(1'b1, 3'd4, 3'd1, 0, 2, 0);

    // single word
    wd_arr[0] = 16'hBEEF;
    burst(1'b1, 3'd5, 3'd0, 0, 0, 0);
    burst(1'b0, 3'd5, 3'd0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rdata_held", rdata, 16'hBEEF);

    // randomized bursts
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) wd_arr[i] = 16'($urandom);
      burst(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 2)) * 2, 0, 0);
    end
    burst(1'b0, 3'd0, 3'd7, 0, 0, 0);

    chk("bus_conflict_cycles", xbus_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
